// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with M/W operand forwarding.
// E registers load a bubble on reset or flush and hold on stall; forwarding is combinational.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCD,
  input  logic [RADDR-1:0] Rs1D,
  input  logic [RADDR-1:0] Rs2D,
  input  logic [RADDR-1:0] RdD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [RADDR-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RADDR-1:0] RdW,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCE,
  output logic [WIDTH-1:0] ImmExtE,
  output logic [RADDR-1:0] Rs1E,
  output logic [RADDR-1:0] Rs2E,
  output logic [RADDR-1:0] RdE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic             reg_write;
    logic             mem_write;
    logic             branch;
    logic             alu_src;
    logic [1:0]       result_src;
    logic [2:0]       alu_ctrl;
  } e_regs_t;

  e_regs_t e_in, e_d, e_q;

  always_comb begin
    e_in.rd1        = RD1D;
    e_in.rd2        = RD2D;
    e_in.imm        = ImmExtD;
    e_in.pc         = PCD;
    e_in.rs1        = Rs1D;
    e_in.rs2        = Rs2D;
    e_in.rd         = RdD;
    e_in.reg_write  = RegWriteD;
    e_in.mem_write  = MemWriteD;
    e_in.branch     = BranchD;
    e_in.alu_src    = ALUSrcD;
    e_in.result_src = ResultSrcD;
    e_in.alu_ctrl   = ALUControlD;
  end

  // Flush outranks stall so a squashed instruction never lingers in E.
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d = e_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  // M is checked first so the newest in-flight value wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RADDR-1:0] rs,
                                         input logic             we_m,
                                         input logic [RADDR-1:0] rd_m,
                                         input logic             we_w,
                                         input logic [RADDR-1:0] rd_w);
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a_sel = fwd_sel(e_q.rs1, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b_sel = fwd_sel(e_q.rs2, RegWriteM, RdM, RegWriteW, RdW);
  end

  always_comb begin
    fwd_a = e_q.rd1;
    case (fwd_a_sel)
      2'b10:   fwd_a = ALUResultM;
      2'b01:   fwd_a = ResultW;
      default: fwd_a = e_q.rd1;
    endcase
  end

  always_comb begin
    fwd_b = e_q.rd2;
    case (fwd_b_sel)
      2'b10:   fwd_b = ALUResultM;
      2'b01:   fwd_b = ResultW;
      default: fwd_b = e_q.rd2;
    endcase
  end

  assign SrcAE       = fwd_a;
  assign SrcBE       = e_q.alu_src ? e_q.imm : fwd_b;
  assign WriteDataE  = fwd_b;
  assign ALUControlE = e_q.alu_ctrl;
  assign PCE         = e_q.pc;
  assign ImmExtE     = e_q.imm;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign ResultSrcE  = e_q.result_src;
  assign ForwardAE   = fwd_a_sel;
  assign ForwardBE   = fwd_b_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
  logic        RegWriteD, MemWriteD, BranchD, ALUSrcD, RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .PCE(PCE), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  typedef struct {
    string       name;
    logic [31:0] srca, srcb, wdata, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, br;
    logic [1:0]  rsrc, fa, fb;
    logic [2:0]  alu;
  } exp_t;

  exp_t cur;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
    end
  endtask

  // Monitor: every negedge, drain pending expectations against the live outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "SrcAE",       SrcAE,              e.srca);
      chk(e.name, "SrcBE",       SrcBE,              e.srcb);
      chk(e.name, "WriteDataE",  WriteDataE,         e.wdata);
      chk(e.name, "PCE",         PCE,                e.pc);
      chk(e.name, "ImmExtE",     ImmExtE,            e.imm);
      chk(e.name, "Rs1E",        {27'd0, Rs1E},      {27'd0, e.rs1});
      chk(e.name, "Rs2E",        {27'd0, Rs2E},      {27'd0, e.rs2});
      chk(e.name, "RdE",         {27'd0, RdE},       {27'd0, e.rd});
      chk(e.name, "RegWriteE",   {31'd0, RegWriteE}, {31'd0, e.rw});
      chk(e.name, "MemWriteE",   {31'd0, MemWriteE}, {31'd0, e.mw});
      chk(e.name, "BranchE",     {31'd0, BranchE},   {31'd0, e.br});
      chk(e.name, "ResultSrcE",  {30'd0, ResultSrcE}, {30'd0, e.rsrc});
      chk(e.name, "ForwardAE",   {30'd0, ForwardAE}, {30'd0, e.fa});
      chk(e.name, "ForwardBE",   {30'd0, ForwardBE}, {30'd0, e.fb});
      chk(e.name, "ALUControlE", {29'd0, ALUControlE}, {29'd0, e.alu});
    end
  end

  task automatic clear_cur();
    cur.srca = '0; cur.srcb = '0; cur.wdata = '0; cur.pc = '0; cur.imm = '0;
    cur.rs1 = '0; cur.rs2 = '0; cur.rd = '0;
    cur.rw = 1'b0; cur.mw = 1'b0; cur.br = 1'b0;
    cur.rsrc = '0; cur.fa = '0; cur.fb = '0; cur.alu = '0;
  endtask

  // Queue an expectation and let the monitor's next negedge consume it.
  task automatic push(input string name);
    cur.name = name;
    sb_q.push_back(cur);
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic br, input logic asrc,
                         input logic [1:0] rsrc, input logic [2:0] alu);
    RD1D = rd1; RD2D = rd2; ImmExtD = imm; PCD = pc;
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RegWriteD = rw; MemWriteD = mw; BranchD = br; ALUSrcD = asrc;
    ResultSrcD = rsrc; ALUControlD = alu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    drive_d(32'hDEADBEEF, 32'hCAFEF00D, 32'h1234, 32'h8000, 5'd7, 5'd9, 5'd11,
            1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 3'b101);
    ALUResultM = 32'h55; RdM = 5'd0; RegWriteM = 1'b1;
    ResultW = 32'h66; RdW = 5'd0; RegWriteW = 1'b1;

    // Reset: two edges with busy D inputs, everything must read zero.
    tick(); tick();
    clear_cur();
    push("reset");

    // Plain load, no forwarding.
    rst = 1'b1; RegWriteM = 1'b0; RegWriteW = 1'b0;
    drive_d(32'd5, 32'd7, 32'h100, 32'h40, 5'd1, 5'd2, 5'd3,
            1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001);
    tick();
    clear_cur();
    cur.srca = 32'd5; cur.srcb = 32'd7; cur.wdata = 32'd7; cur.pc = 32'h40; cur.imm = 32'h100;
    cur.rs1 = 5'd1; cur.rs2 = 5'd2; cur.rd = 5'd3; cur.rw = 1'b1; cur.rsrc = 2'b01;
    cur.alu = 3'b001;
    push("load");

    // Forward priority: M and W both match Rs1E=4, M wins.
    drive_d(32'hAA, 32'hBB, 32'h8, 32'h80, 5'd4, 5'd5, 5'd7,
            1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b010);
    RegWriteM = 1'b1; RdM = 5'd4; ALUResultM = 32'h11;
    RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h22;
    tick();
    clear_cur();
    cur.srca = 32'h11; cur.srcb = 32'hBB; cur.wdata = 32'hBB; cur.pc = 32'h80; cur.imm = 32'h8;
    cur.rs1 = 5'd4; cur.rs2 = 5'd5; cur.rd = 5'd7; cur.mw = 1'b1; cur.br = 1'b1;
    cur.rsrc = 2'b10; cur.alu = 3'b010; cur.fa = 2'b10;
    push("fwd_m");

    RegWriteM = 1'b0;
    cur.fa = 2'b01; cur.srca = 32'h22;
    push("fwd_w");

    RdW = 5'd5;
    cur.fa = 2'b00; cur.srca = 32'hAA;
    cur.fb = 2'b01; cur.srcb = 32'h22; cur.wdata = 32'h22;
    push("fwd_b_w");

    // x0 is never forwarded even when M writes register 0.
    drive_d(32'd0, 32'd0, 32'h4, 32'hC0, 5'd0, 5'd0, 5'd9,
            1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b101);
    RegWriteM = 1'b1; RdM = 5'd0; ALUResultM = 32'hFF; RegWriteW = 1'b0;
    tick();
    clear_cur();
    cur.pc = 32'hC0; cur.imm = 32'h4; cur.rd = 5'd9; cur.rw = 1'b1; cur.alu = 3'b101;
    push("x0");

    // Immediate selects SrcBE while store data still carries the forwarded value.
    drive_d(32'd0, 32'h33, 32'hFFFF_FFF0, 32'hC4, 5'd0, 5'd8, 5'd9,
            1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
    RdM = 5'd8; ALUResultM = 32'h9;
    tick();
    clear_cur();
    cur.srcb = 32'hFFFF_FFF0; cur.wdata = 32'h9; cur.fb = 2'b10; cur.pc = 32'hC4;
    cur.imm = 32'hFFFF_FFF0; cur.rs2 = 5'd8; cur.rd = 5'd9; cur.rw = 1'b1;
    push("imm");

    // Stall holds E contents against new D inputs.
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    drive_d(32'h61, 32'h62, 32'h60, 32'h100, 5'd10, 5'd11, 5'd6,
            1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000);
    tick();
    clear_cur();
    cur.srca = 32'h61; cur.srcb = 32'h62; cur.wdata = 32'h62; cur.pc = 32'h100;
    cur.imm = 32'h60; cur.rs1 = 5'd10; cur.rs2 = 5'd11; cur.rd = 5'd6; cur.rw = 1'b1;
    cur.rsrc = 2'b01;
    push("pre_stall");

    StallE = 1'b1;
    drive_d(32'h99, 32'h98, 32'h97, 32'h200, 5'd13, 5'd14, 5'd12,
            1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 3'b011);
    tick(); tick();
    push("stall");

    // Forwarding muxes stay live while stalled.
    RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h77;
    cur.fa = 2'b01; cur.srca = 32'h77;
    push("stall_fwd");

    // Flush beats stall.
    FlushE = 1'b1;
    tick();
    clear_cur();
    push("flush");

    // Reload, then reset mid-stream while stalled.
    FlushE = 1'b0; StallE = 1'b0; RegWriteW = 1'b0;
    drive_d(32'h61, 32'h62, 32'h60, 32'h100, 5'd10, 5'd11, 5'd6,
            1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000);
    tick();
    cur.srca = 32'h61; cur.srcb = 32'h62; cur.wdata = 32'h62; cur.pc = 32'h100;
    cur.imm = 32'h60; cur.rs1 = 5'd10; cur.rs2 = 5'd11; cur.rd = 5'd6; cur.rw = 1'b1;
    cur.rsrc = 2'b01;
    push("reload");

    StallE = 1'b1; rst = 1'b0;
    tick();
    clear_cur();
    push("rst_mid");

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
